// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer, stall (lock) and flush.
// Latency: 1 cycle from accept to out_valid; sustains one transfer per cycle while out_ready=1.
// Backpressure: in_ready drops when both entries are held or lock=1; optional stats via PIPE_BUF_STATS_EN.
module pipe_stage_buffer #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 16,
  parameter logic [DATA_W-1:0]  NOP_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              lock,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_is_nop
`ifdef PIPE_BUF_STATS_EN
  ,
  output logic [15:0]       stat_stall_cnt,
  output logic [15:0]       stat_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                accept;
  logic                drain;

  // Handshake outputs come from the registered state; lock hides the head and blocks upstream.
  always_comb begin
    in_ready   = (state_q != FULL) && !lock;
    out_valid  = (state_q != EMPTY) && !lock;
    out_is_nop = !out_valid;
    out_data   = out_valid ? main_data_q : NOP_DATA;
    out_ctrl   = out_valid ? main_ctrl_q : '0;
    accept     = in_valid && in_ready && !flush;
    drain      = out_valid && out_ready && !flush;
  end

  // Next-state and register-load decisions; main is always the oldest entry.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      // Held entries are discarded by forgetting them; stale data stays masked.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = FULL;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= EMPTY;
      main_data_q <= NOP_DATA;
      main_ctrl_q <= '0;
      skid_data_q <= NOP_DATA;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef PIPE_BUF_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: stalled head or lock, and flushes that discard something.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (((out_valid && !out_ready) || lock) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush && (state_q != EMPTY) && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer with a scoreboard of accepted entries.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Every drained entry is compared against the oldest queued expectation.
module tb_pipe_stage_buffer;
  localparam int          DATA_W = 32;
  localparam int          CTRL_W = 16;
  localparam logic [31:0] NOP    = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              lock;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_is_nop;
`ifdef PIPE_BUF_STATS_EN
  logic [15:0]       stat_stall_cnt;
  logic [15:0]       stat_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [47:0] sb[$];
  logic        obs_ir, obs_ov;
  logic [31:0] obs_od;
  logic [15:0] obs_oc;

  pipe_stage_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_DATA(NOP)) dut (
    .clk(clk), .rst_b(rst_b), .lock(lock), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_is_nop(out_is_nop)
`ifdef PIPE_BUF_STATS_EN
    ,
    .stat_stall_cnt(stat_stall_cnt),
    .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ctrl_of(input logic [31:0] d);
    return d[15:0] ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, sample on the falling edge, update scoreboard, advance.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy,
                     input logic lk, input logic fl);
    logic [47:0] e;
    in_valid = iv; in_data = d; in_ctrl = ctrl_of(d);
    out_ready = ordy; lock = lk; flush = fl;
    @(negedge clk);
    obs_ir = in_ready; obs_ov = out_valid; obs_od = out_data; obs_oc = out_ctrl;
    chk("is_nop", {63'd0, out_is_nop}, {63'd0, ~obs_ov});
    if (!obs_ov) begin
      chk("mask_data", {32'd0, obs_od}, {32'd0, NOP});
      chk("mask_ctrl", {48'd0, obs_oc}, 64'd0);
    end
    if (obs_ov && ordy && !lk && !fl) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", {32'd0, obs_od}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_data", {32'd0, obs_od}, {32'd0, e[31:0]});
        chk("sb_ctrl", {48'd0, obs_oc}, {48'd0, e[47:32]});
      end
    end
    if (iv && obs_ir && !lk && !fl) sb.push_back({ctrl_of(d), d});
    if (fl) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_b = 1'b0; lock = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;

    // Reset
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_ov",   {63'd0, out_valid},  64'd0);
    chk("rst_ctrl", {48'd0, out_ctrl},   64'd0);
    chk("rst_data", {32'd0, out_data},   {32'd0, NOP});
    chk("rst_nop",  {63'd0, out_is_nop}, 64'd1);
    @(posedge clk); #1;
    rst_b = 1'b1;
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("rst_ir", {63'd0, obs_ir}, 64'd1);

    // Streaming 1..8 with 1-cycle latency
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_ir", {63'd0, obs_ir}, 64'd1);
      chk("stream_ov", {63'd0, obs_ov}, (i == 1) ? 64'd0 : 64'd1);
      if (i > 1) chk("stream_dat", {32'd0, obs_od}, 64'(i - 1));
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("stream_last", {32'd0, obs_od}, 64'd8);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("stream_idle", {63'd0, obs_ov}, 64'd0);

    // Backpressure: A,B held, C stalls upstream
    cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    chk("bp_ir_b", {63'd0, obs_ir}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
      chk("bp_ir_full", {63'd0, obs_ir}, 64'd0);
      chk("bp_head",    {32'd0, obs_od}, 64'hA);
    end
    cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    chk("bp_rel_a", {32'd0, obs_od}, 64'hA);
    cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    chk("bp_rel_b", {32'd0, obs_od}, 64'hB);
    chk("bp_c_acc", {63'd0, obs_ir}, 64'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("bp_rel_c", {32'd0, obs_od}, 64'hC);
    chk("bp_empty", 64'(sb.size()), 64'd0);

    // Lock while FULL
    cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
      chk("lock_ov",   {63'd0, obs_ov}, 64'd0);
      chk("lock_ir",   {63'd0, obs_ir}, 64'd0);
      chk("lock_ctrl", {48'd0, obs_oc}, 64'd0);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("unlock_a", {32'd0, obs_od}, 64'h11);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("unlock_b", {32'd0, obs_od}, 64'h22);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("unlock_empty", {63'd0, obs_ov}, 64'd0);

    // Reset mid-transfer discards entries
    cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    sb.delete();
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("mrst_ov", {63'd0, obs_ov}, 64'd0);
    chk("mrst_ir", {63'd0, obs_ir}, 64'd1);

    // Flush while FULL with a same-cycle input
    cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("flush_ov",   {63'd0, obs_ov}, 64'd0);
    chk("flush_ctrl", {48'd0, obs_oc}, 64'd0);
    chk("flush_ir",   {63'd0, obs_ir}, 64'd1);
`ifdef PIPE_BUF_STATS_EN
    chk("stat_flush", {48'd0, stat_flush_cnt}, 64'd1);
`endif

    // Random handshake mix
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), 32'h1000 + 32'(i), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    drain_all();

`ifdef PIPE_BUF_STATS_EN
    // Long downstream stall saturates the stall counter and loses nothing
    cyc(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stat_stall_sat", {48'd0, stat_stall_cnt}, 64'hFFFF);
    @(posedge clk); #1;
    drain_all();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
